// File: rtl/packetizer_ctrl_pkg.sv
// packetizer_ctrl_pkg: shared register map, AXI response codes and sequencer state type.
package packetizer_ctrl_pkg;
  localparam logic [31:0] ADDR_CONFIG = 32'h0000_0200;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0204;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, ARM_WR, ARM_B, RUN, DISARM_WR, DISARM_B} state_t;
endpackage

// File: rtl/packetizer_ctrl_if.sv
// packetizer_ctrl_if: AXI4-Lite write-only manager bus (AW, W, B channels).
//   master: drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready
//   slave : drives awready, wready, bresp/bvalid
interface packetizer_ctrl_if;
  logic [31:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master(output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                 input awready, wready, bresp, bvalid);
  modport slave(input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                output awready, wready, bresp, bvalid);
endinterface

// File: rtl/packetizer_ctrl_axil_single_write.sv
// packetizer_ctrl_axil_single_write: issues one AW+W to a fixed address, collects B, flags ok/err/timeout.
//   clk, rst          clock, async active-high reset
//   en_wr_i           write phase: present AW/W until each is accepted
//   en_b_i            response phase: bready held high
//   data_i            write data
//   m                 AXI4-Lite manager bus
//   wr_done_o         both AW and W accepted this cycle (or earlier in the phase)
//   b_ok_o, b_err_o   B accepted this cycle with OKAY / non-OKAY
//   tmo_o             phase exceeded TMO cycles (TMO=0 disables)
module packetizer_ctrl_axil_single_write
  import packetizer_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR = ADDR_CONFIG,
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en_wr_i,
  input  logic en_b_i,
  input  logic [31:0] data_i,
  packetizer_ctrl_if.master m,
  output logic wr_done_o,
  output logic b_ok_o,
  output logic b_err_o,
  output logic tmo_o
);
  localparam int CW = $clog2(TMO + 2);
  logic aw_done_q, w_done_q, aw_done_d, w_done_d, aw_hs, w_hs, b_hs, evt, act;
  logic [CW-1:0] cnt_q, cnt_d;
  assign m.awaddr = ADDR;
  assign m.awprot = 3'b000;
  assign m.wstrb = 4'hF;
  assign m.wdata = data_i;
  // Each valid drops only after its own handshake, so AW and W may complete in different cycles.
  assign m.awvalid = en_wr_i & ~aw_done_q;
  assign m.wvalid = en_wr_i & ~w_done_q;
  assign m.bready = en_b_i;
  assign aw_hs = m.awvalid & m.awready;
  assign w_hs = m.wvalid & m.wready;
  assign b_hs = m.bready & m.bvalid;
  assign act = en_wr_i | en_b_i;
  assign wr_done_o = en_wr_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign b_ok_o = b_hs & (m.bresp == RESP_OKAY);
  assign b_err_o = b_hs & (m.bresp != RESP_OKAY);
  assign evt = wr_done_o | b_hs;
  // Counter restarts on every phase change, so the limit applies per phase.
  assign tmo_o = (TMO != 0) & act & ~evt & (cnt_q == CW'(TMO));
  assign aw_done_d = en_wr_i & ~wr_done_o & (aw_done_q | aw_hs);
  assign w_done_d = en_wr_i & ~wr_done_o & (w_done_q | w_hs);
  assign cnt_d = (evt | ~act) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/packetizer_ctrl.sv
// packetizer_ctrl: arms the packetizer over AXI4-Lite, counts packets, disarms; reports done/err.
//   aclk, areset         clock, async active-high reset
//   start, abort         1-cycle pulses: begin run / stop run early
//   cfg_samples          beats per packet (>=2), sampled on start
//   cfg_packets          packets per run (>=1), sampled on start
//   pkt_last, pkt_beat   packetizer tlast and stream beat
//   busy                 run in progress
//   done                 1-cycle pulse on clean completion
//   err                  sticky error, cleared by next accepted start
//   packets_done         packets counted in current/last run
//   m_axi_lite           AXI4-Lite manager bus to packetizer config
module packetizer_ctrl
  import packetizer_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] CFG_OFFSET = ADDR_CONFIG,
  parameter int PKT_CNT_W = 16,
  parameter int BRESP_TMO = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic start,
  input  logic abort,
  input  logic [31:0] cfg_samples,
  input  logic [PKT_CNT_W-1:0] cfg_packets,
  input  logic pkt_last,
  input  logic pkt_beat,
  output logic busy,
  output logic done,
  output logic err,
  output logic [PKT_CNT_W-1:0] packets_done,
  packetizer_ctrl_if.master m_axi_lite
);
  state_t state_q, state_d;
  logic [31:0] samples_q, samples_d;
  logic [PKT_CNT_W-1:0] packets_q, packets_d, cnt_q, cnt_d;
  logic err_q, err_d, done_q, done_d, abort_q, abort_d;
  logic wr_done, b_ok, b_err, tmo, pkt, bad_cfg;
  assign pkt = pkt_last & pkt_beat;
  assign bad_cfg = (cfg_samples < 32'd2) | (cfg_packets == '0);
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign packets_done = cnt_q;
  // The packetizer emits N+1 beats per packet, hence samples-1 on arm; disarm writes 0.
  packetizer_ctrl_axil_single_write #(.ADDR(BASE_ADDR + CFG_OFFSET), .TMO(BRESP_TMO)) u_wr (
    .clk(aclk),
    .rst(areset),
    .en_wr_i(state_q == ARM_WR || state_q == DISARM_WR),
    .en_b_i(state_q == ARM_B || state_q == DISARM_B),
    .data_i(state_q == ARM_WR ? samples_q - 32'd1 : 32'd0),
    .m(m_axi_lite),
    .wr_done_o(wr_done),
    .b_ok_o(b_ok),
    .b_err_o(b_err),
    .tmo_o(tmo)
  );
  always_comb begin
    state_d = state_q;
    samples_d = samples_q;
    packets_d = packets_q;
    cnt_d = cnt_q;
    err_d = err_q;
    abort_d = abort_q;
    done_d = 1'b0;
    case (state_q)
      IDLE:
        if (start) begin
          if (bad_cfg) err_d = 1'b1;
          else begin
            samples_d = cfg_samples;
            packets_d = cfg_packets;
            cnt_d = '0;
            err_d = 1'b0;
            abort_d = 1'b0;
            state_d = ARM_WR;
          end
        end
      // An abort during arming lets the arm write finish, then disarms.
      ARM_WR: begin
        abort_d = abort_q | abort;
        if (tmo) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (wr_done) state_d = ARM_B;
      end
      ARM_B: begin
        abort_d = abort_q | abort;
        if (tmo | b_err) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (b_ok) state_d = (abort_q | abort) ? DISARM_WR : RUN;
      end
      // A packet ending in the abort cycle still counts; the count saturates at cfg_packets.
      RUN: begin
        cnt_d = cnt_q + PKT_CNT_W'(pkt && cnt_q != packets_q);
        state_d = (abort || cnt_d == packets_q) ? DISARM_WR : RUN;
      end
      DISARM_WR:
        if (tmo) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (wr_done) state_d = DISARM_B;
      DISARM_B:
        if (tmo | b_err) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (b_ok) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= IDLE;
      samples_q <= '0;
      packets_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samples_q <= samples_d;
      packets_q <= packets_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      done_q <= done_d;
      abort_q <= abort_d;
    end
endmodule

// File: tb/tb_packetizer_ctrl.sv
// tb_packetizer_ctrl: scoreboard bench; expected AXI writes queued at start, matched as the DUT writes.
module tb_packetizer_ctrl;
  import packetizer_ctrl_pkg::*;
  localparam int TMO = 32;
  localparam logic [31:0] CA = 32'h0000_0200;
  logic aclk = 1'b0, areset = 1'b1, start = 1'b0, abort = 1'b0, pkt_last = 1'b0, pkt_beat = 1'b0;
  logic [31:0] cfg_samples = '0;
  logic [15:0] cfg_packets = '0;
  logic busy, done, err;
  logic [15:0] packets_done;
  packetizer_ctrl_if bus();
  packetizer_ctrl #(.BRESP_TMO(TMO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .cfg_samples(cfg_samples), .cfg_packets(cfg_packets),
    .pkt_last(pkt_last), .pkt_beat(pkt_beat),
    .busy(busy), .done(done), .err(err), .packets_done(packets_done),
    .m_axi_lite(bus)
  );
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  logic [63:0] sb[$];
  int aw_wait = 0, w_wait = 0, n_wr = 0, n_b = 0, n_done = 0;
  logic [1:0] b_resp_cfg = RESP_OKAY;
  bit no_b = 0;
  // AXI subordinate model: programmable AW/W stalls, B response code, optional missing B.
  initial begin
    bit aw_got = 0, w_got = 0, aw_pend = 0, w_pend = 0, b_sched = 0, b_fin = 0;
    logic [31:0] a = '0, d = '0, d_prev = '0;
    bus.awready = 1'b0;
    bus.wready = 1'b0;
    bus.bvalid = 1'b0;
    bus.bresp = RESP_OKAY;
    forever begin
      @(posedge aclk);
      #1;
      if (done) n_done++;
      if (areset) begin
        aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; b_sched = 0; b_fin = 0;
        bus.bvalid = 1'b0;
        continue;
      end
      if (b_fin) begin
        bus.bvalid = 1'b0;
        n_b++;
        b_fin = 0;
      end
      if (b_sched && !no_b) begin
        bus.bvalid = 1'b1;
        bus.bresp = b_resp_cfg;
      end
      b_sched = 0;
      b_fin = bus.bvalid && bus.bready;
      if (aw_pend) check("aw_held", bus.awvalid, 1);
      if (w_pend) begin
        check("w_held", bus.wvalid, 1);
        check("w_data_held", bus.wdata, d_prev);
      end
      bus.awready = aw_wait == 0;
      if (bus.awvalid && aw_wait > 0) aw_wait--;
      bus.wready = w_wait == 0;
      if (bus.wvalid && w_wait > 0) w_wait--;
      aw_pend = bus.awvalid && !bus.awready;
      w_pend = bus.wvalid && !bus.wready;
      d_prev = bus.wdata;
      if (bus.awvalid && bus.awready) begin
        aw_got = 1;
        a = bus.awaddr;
        check("awprot", bus.awprot, 0);
      end
      if (bus.wvalid && bus.wready) begin
        w_got = 1;
        d = bus.wdata;
        check("wstrb", bus.wstrb, 4'hF);
      end
      if (aw_got && w_got) begin
        aw_got = 0;
        w_got = 0;
        n_wr++;
        b_sched = 1;
        check("write_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check("write", {a, d}, sb.pop_front());
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic go(logic [31:0] s, logic [15:0] p);
    cfg_samples = s;
    cfg_packets = p;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic pulse_abort();
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
  endtask
  task automatic wait_b(int target);
    for (int i = 0; i < 300 && n_b < target; i++) cyc(1);
    check("b_count", n_b, target);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) cyc(1);
    check("idle", busy, 0);
    cyc(2);
  endtask
  task automatic beats(int n, int per);
    for (int i = 1; i <= n; i++) begin
      pkt_beat = 1'b1;
      pkt_last = (i % per) == 0;
      cyc(1);
    end
    pkt_beat = 1'b0;
    pkt_last = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, w0;
    cyc(3);
    check("rst_flags", {busy, done, err, bus.awvalid, bus.wvalid, bus.bready}, 0);
    check("rst_pkts", packets_done, 0);
    areset = 1'b0;
    cyc(2);
    // arm / run / disarm; extra packet after the last one is outside RUN
    sb.push_back({CA, 32'd3});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(4, 3);
    check("t1_busy", busy, 1);
    wait_b(1);
    beats(16, 4);
    wait_idle();
    check("t1_pkts", packets_done, 3);
    check("t1_done", n_done - d0, 1);
    check("t1_err", err, 0);
    check("t1_writes", n_wr, 2);
    check("t1_sb", sb.size(), 0);
    // stalled AW accept, W early
    aw_wait = 20;
    sb.push_back({CA, 32'd5});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(6, 1);
    wait_b(3);
    beats(4, 4);
    wait_idle();
    check("t2_done", n_done - d0, 1);
    check("t2_err", err, 0);
    check("t2_writes", n_wr, 4);
    check("t2_sb", sb.size(), 0);
    // abort in RUN after two packets
    sb.push_back({CA, 32'd7});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(8, 10);
    wait_b(5);
    beats(16, 8);
    pulse_abort();
    wait_idle();
    check("t3_pkts", packets_done, 2);
    check("t3_done", n_done - d0, 1);
    check("t3_err", err, 0);
    check("t3_sb", sb.size(), 0);
    // SLVERR on arm, then a clean run clears err
    b_resp_cfg = RESP_SLVERR;
    sb.push_back({CA, 32'd3});
    d0 = n_done;
    go(4, 1);
    wait_b(7);
    b_resp_cfg = RESP_OKAY;
    wait_idle();
    beats(4, 4);
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_done", n_done - d0, 0);
    check("t4_pkts", packets_done, 0);
    check("t4_sb", sb.size(), 0);
    sb.push_back({CA, 32'd3});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(4, 1);
    check("t4_err_clr", err, 0);
    wait_b(8);
    beats(4, 4);
    wait_idle();
    check("t4b_done", n_done - d0, 1);
    check("t4b_pkts", packets_done, 1);
    // bad configuration
    w0 = n_wr;
    go(1, 1);
    cyc(3);
    check("t5_err_s", err, 1);
    check("t5_busy_s", busy, 0);
    go(4, 0);
    cyc(3);
    check("t5_err_p", err, 1);
    check("t5_busy_p", busy, 0);
    check("t5_writes", n_wr, w0);
    // abort while arm write is stalled
    aw_wait = 5;
    sb.push_back({CA, 32'd7});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(8, 4);
    check("t6_err_clr", err, 0);
    pulse_abort();
    wait_idle();
    check("t6_pkts", packets_done, 0);
    check("t6_done", n_done - d0, 1);
    check("t6_err", err, 0);
    check("t6_sb", sb.size(), 0);
    // missing B response -> timeout
    no_b = 1;
    sb.push_back({CA, 32'd3});
    d0 = n_done;
    go(4, 1);
    wait_idle();
    no_b = 0;
    check("t7_err", err, 1);
    check("t7_done", n_done - d0, 0);
    check("t7_bready", bus.bready, 0);
    check("t7_sb", sb.size(), 0);
    // async reset mid-RUN, then a new run
    sb.push_back({CA, 32'd3});
    go(4, 5);
    wait_b(12);
    beats(4, 4);
    check("t8_pkts_pre", packets_done, 1);
    check("t8_busy_pre", busy, 1);
    #3 areset = 1'b1;
    #1;
    check("t8_rst_flags", {busy, done, err, bus.awvalid, bus.wvalid, bus.bready}, 0);
    check("t8_rst_pkts", packets_done, 0);
    cyc(2);
    areset = 1'b0;
    cyc(2);
    sb.push_back({CA, 32'd3});
    sb.push_back({CA, 32'd0});
    d0 = n_done;
    go(4, 1);
    wait_b(13);
    beats(4, 4);
    wait_idle();
    check("t8_done", n_done - d0, 1);
    check("t8_pkts", packets_done, 1);
    check("t8_err", err, 0);
    check("t8_sb", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
